// File: rtl/sp_ram_bist_if.sv
// RAM-side bus between the march-test controller and the single-port RAM.
// The controller drives address/data/write-enable and consumes the read word.
interface sp_ram_bist_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] ram_data;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        output ram_data,
        output ram_addr,
        output ram_we,
        input  ram_q
    );

    modport slave (
        input  ram_data,
        input  ram_addr,
        input  ram_we,
        output ram_q
    );
endinterface

// File: rtl/sp_ram_bist.sv
// Four-phase march BIST (write P up, read P up, write ~P down, read ~P down)
// for a single-port RAM with one-cycle registered read data.
module sp_ram_bist #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = {(DATA_WIDTH/2){2'b01}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [15:0]           fail_cnt,
    sp_ram_bist_if.master         ram
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_P, S_RD_P, S_WR_N, S_RD_N, S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_busy, r_done, r_pass, r_ram_we;
    logic [ADDR_WIDTH-1:0] r_fail_addr, r_ram_addr, r_cmp_addr;
    logic [15:0]           r_fail_cnt;
    logic [DATA_WIDTH-1:0] r_ram_data, r_cmp_exp;
    logic                  r_cmp_valid;

    logic                  w_busy_next, w_done_next, w_pass_next, w_we_next;
    logic [ADDR_WIDTH-1:0] w_addr_next, w_fail_addr_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic [15:0]           w_fail_cnt_next;
    logic                  w_term, w_start_ok, w_mismatch, w_cmp_issue;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_cmp_issue = (r_state == S_RD_P) || (r_state == S_RD_N);

    // Ascending phases end on the top address, descending phases on zero.
    always_comb begin
        w_term = 1'b0;
        case (r_state)
            S_WR_P, S_RD_P: w_term = (r_ram_addr == LAST_ADDR);
            S_WR_N, S_RD_N: w_term = (r_ram_addr == '0);
            default:        w_term = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_WR_P;
            S_WR_P:  if (w_term) w_state_next = S_RD_P;
            S_RD_P:  if (w_term) w_state_next = S_WR_N;
            S_WR_N:  if (w_term) w_state_next = S_RD_N;
            S_RD_N:  if (w_term) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The compare runs one cycle behind each read, independent of the state.
    always_comb begin
        w_mismatch       = r_cmp_valid && (ram.ram_q !== r_cmp_exp);
        w_fail_cnt_next  = r_fail_cnt;
        w_fail_addr_next = r_fail_addr;
        if (w_start_ok) begin
            w_fail_cnt_next  = '0;
            w_fail_addr_next = '0;
        end else if (w_mismatch) begin
            if (r_fail_cnt != 16'hFFFF)
                w_fail_cnt_next = r_fail_cnt + 16'd1;
            if (r_fail_cnt == 16'd0)
                w_fail_addr_next = r_cmp_addr;
        end
    end

    // Outputs are registered, so this block computes the operation of the next cycle.
    always_comb begin
        w_busy_next = r_busy;
        w_done_next = 1'b0;
        w_pass_next = r_pass;
        w_we_next   = 1'b0;
        w_addr_next = r_ram_addr;
        w_data_next = r_ram_data;
        case (r_state)
            S_IDLE: if (start) begin
                w_busy_next = 1'b1;
                w_pass_next = 1'b0;
                w_we_next   = 1'b1;
                w_addr_next = '0;
                w_data_next = PATTERN;
            end
            S_WR_P: begin
                w_we_next   = !w_term;
                w_addr_next = w_term ? '0 : r_ram_addr + ADDR_WIDTH'(1);
            end
            S_RD_P: begin
                w_we_next   = w_term;
                w_addr_next = w_term ? LAST_ADDR : r_ram_addr + ADDR_WIDTH'(1);
                if (w_term) w_data_next = ~PATTERN;
            end
            S_WR_N: begin
                w_we_next   = !w_term;
                w_addr_next = w_term ? LAST_ADDR : r_ram_addr - ADDR_WIDTH'(1);
            end
            S_RD_N: begin
                if (!w_term) w_addr_next = r_ram_addr - ADDR_WIDTH'(1);
            end
            S_DRAIN: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b1;
                w_pass_next = (w_fail_cnt_next == 16'd0);
            end
            default: w_busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_cnt  <= '0;
            r_ram_data  <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
            r_fail_addr <= w_fail_addr_next;
            r_fail_cnt  <= w_fail_cnt_next;
            r_ram_data  <= w_data_next;
            r_ram_addr  <= w_addr_next;
            r_ram_we    <= w_we_next;
            r_cmp_valid <= w_cmp_issue;
            r_cmp_exp   <= (r_state == S_RD_P) ? PATTERN : ~PATTERN;
            r_cmp_addr  <= r_ram_addr;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail_addr    = r_fail_addr;
    assign fail_cnt     = r_fail_cnt;
    assign ram.ram_data = r_ram_data;
    assign ram.ram_addr = r_ram_addr;
    assign ram.ram_we   = r_ram_we;
endmodule

// File: doc/sp_ram_bist.md
# sp_ram_bist

Built-in self-test controller for the single-port `sp_ram` block. It sits directly upstream of the RAM, driving its `data`, `addr` and `we` pins, and directly downstream of it, consuming `q`. On a `start` pulse it runs a four-phase march test over every address and reports `pass`, the first failing address and a saturating error count. The same RAM port is also used by the post-route netlist bench.

## Interface
Parameters:
- `DATA_WIDTH`, 32, RAM word width; must be even.
- `ADDR_WIDTH`, 10, RAM address width.
- `DEPTH`, 1024, number of words tested; must be ≤ 2**ADDR_WIDTH and ≥ 2.
- `PATTERN`, {DATA_WIDTH/2{2'b01}} (0x5555_5555 at default width), background pattern P.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a test; honoured only in IDLE.
- `busy`  out  1  high while a test runs.
- `done`  out  1  one-cycle pulse at test end.
- `pass`  out  1  result of the last test; valid from `done` until the next `start`.
- `fail_addr`  out  ADDR_WIDTH  address of the first mismatch in the last test.
- `fail_cnt`  out  16  number of mismatching reads; saturates at 0xFFFF.
- `ram_data`  out  DATA_WIDTH  drives `sp_ram.data`.
- `ram_addr`  out  ADDR_WIDTH  drives `sp_ram.addr`.
- `ram_we`  out  1  drives `sp_ram.we`.
- `ram_q`  in  DATA_WIDTH  from `sp_ram.q`; holds the word addressed at the previous edge when `we=0`.

## Operation
- All outputs are registered. Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_cnt`=0, `ram_data`=0, `ram_addr`=0, `ram_we`=0.
- States: IDLE → WR_P → RD_P → WR_N → RD_N → DRAIN → IDLE.
  - WR_P: write P, ascending addresses 0..DEPTH-1.
  - RD_P: read, ascending, expecting P.
  - WR_N: write ~P, descending DEPTH-1..0.
  - RD_N: read, descending, expecting ~P.
- Each state issues one RAM operation per cycle for exactly DEPTH cycles, then moves to the next state. RD_N moves to DRAIN for 1 cycle.
- On `start` in IDLE, the controller:
  - clears `fail_cnt` and `fail_addr`;
  - clears `pass`;
  - enters WR_P.
- `start` outside IDLE is ignored.
- Compare pipeline: each read issue registers `cmp_valid`=1, the expected word and the address.
- In the following cycle, `ram_q` is compared against the expected word. This compare runs independently of the state, so the last RD_P read is checked during the first WR_N cycle, and the last RD_N read is checked in DRAIN.
- On a mismatch:
  - `fail_cnt` increments, saturating;
  - if `fail_cnt` was 0, `fail_addr` captures the compare address.
- Any X/Z bit on `ram_q` counts as a mismatch in simulation.
- DRAIN exit: `done`=1 for one cycle, `pass`=(final `fail_cnt`==0), `busy`=0.
- `ram_we` is 1 only in WR_P/WR_N. `ram_data` holds its last value during reads.
- `rst` mid-test: at the next edge all outputs return to their reset values, `ram_we` drops, the compare pipeline is flushed and the state returns to IDLE. No `done` pulse is generated.
- Address counters are ADDR_WIDTH wide and never wrap beyond DEPTH-1 or below 0. The phase ends on the terminal address.

## Timing
- Let `start` be sampled at edge E0. After E0: `busy`=1, `ram_we`=1, `ram_addr`=0, `ram_data`=P.
- RAM operations occupy the cycles after edges E0 .. E0+4·DEPTH−1. DRAIN is the cycle after E0+4·DEPTH.
- After edge E0+4·DEPTH+1: `done`=1, `busy`=0, `pass`/`fail_*` final.
- `busy` is high for exactly 4·DEPTH+1 cycles: 65 cycles for DEPTH=16, 4097 cycles for DEPTH=1024.
- Read latency budget: `ram_q` is sampled one cycle after the read address is presented.
- A new `start` is accepted in the cycle `done` is high. Back-to-back tests have one IDLE cycle between them.

## Test plan
- Fault-free `sp_ram` model, DEPTH=16, pulse `start` → `busy` high 65 cycles, `done` one cycle, `pass`=1, `fail_cnt`=0.
- Model with addr 5, bit 3 stuck-at-0, DEPTH=16 → only the RD_N read fails; `pass`=0, `fail_addr`=5, `fail_cnt`=1.
- Model with bit 0 stuck-at-1 at addresses 2 and 9 → RD_N failures in descending order; `fail_addr`=9, `fail_cnt`=2.
- `start` pulsed again at cycles 10 and 40 of a running test → ignored: same 65-cycle duration, single `done`.
- `rst` asserted at cycle 20 of a test → after the next edge `ram_we`=0, `busy`=0, `fail_cnt`=0; no `done`. A following `start` runs a full passing test.
- `start` in the `done` cycle → second test begins; `fail_cnt` cleared; `done` appears 66 cycles after the first.
